// File: rtl/req_arbiter.sv
// Round-robin request arbiter: one-hot registered grant with a rotating
// search pointer, a mandatory dead cycle between grants and an optional hold limit.
module req_arbiter #(
    parameter int N        = 8,
    parameter int ID_W     = 3,
    parameter int MAX_HOLD = 15
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [N-1:0]    req,
    input  logic            release_grant,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            busy,
    output logic            timeout
);

    // A zero-width counter is illegal, so keep one bit when the limit is disabled.
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state_reg;
    logic [ID_W-1:0]   ptr_reg;
    logic [HOLD_W-1:0] hold_reg;

    logic [ID_W-1:0]   pick_id;
    logic              pick_valid;
    logic [N-1:0]      pick_onehot;
    logic [ID_W-1:0]   next_ptr;
    logic              hold_expire;
    logic              owner_req;
    logic              grant_exit;

    // Scan upward from ptr_reg (inclusive), wrapping N-1 -> 0.
    always_comb begin
        int idx;
        idx        = 0;
        pick_id    = '0;
        pick_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_reg) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!pick_valid && req[idx]) begin
                pick_valid = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign pick_onehot[gi] = pick_valid && (pick_id == ID_W'(gi));
        end
    endgenerate

    assign next_ptr    = (grant_id == ID_W'(N - 1)) ? '0 : grant_id + 1'b1;
    assign hold_expire = (MAX_HOLD != 0) && (hold_reg == HOLD_W'(MAX_HOLD - 1));
    assign owner_req   = req[grant_id];
    assign grant_exit  = release_grant || !owner_req || hold_expire;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            grant     <= '0;
            grant_id  <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
            ptr_reg   <= '0;
            hold_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    timeout <= 1'b0;
                    if (pick_valid) begin
                        state_reg <= GRANT;
                        grant     <= pick_onehot;
                        grant_id  <= pick_id;
                        busy      <= 1'b1;
                        hold_reg  <= '0;
                    end
                end
                GRANT: begin
                    if (grant_exit) begin
                        state_reg <= IDLE;
                        grant     <= '0;
                        busy      <= 1'b0;
                        hold_reg  <= '0;
                        ptr_reg   <= next_ptr;
                        // A voluntary exit on the same cycle wins over the hold limit.
                        timeout   <= hold_expire && !release_grant && owner_req;
                    end else if (hold_reg != '1) begin
                        hold_reg <= hold_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_arbiter.sv
// Directed bench for req_arbiter (N=8, MAX_HOLD=4) with hand-computed expectations.
module tb_req_arbiter;

    logic       clock;
    logic       reset_n;
    logic [7:0] req;
    logic       release_grant;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       busy;
    logic       timeout;

    int vectors;
    int miscompares;

    req_arbiter #(
        .N        (8),
        .ID_W     (3),
        .MAX_HOLD (4)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .req           (req),
        .release_grant (release_grant),
        .grant         (grant),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout       (timeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] g, input logic [2:0] id,
                           input logic b, input logic t);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".grant_id"}, 32'(grant_id), 32'(id));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".timeout"}, 32'(timeout), 32'(t));
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        req           = 8'h00;
        release_grant = 1'b0;
        reset_n       = 1'b1;
        #1 reset_n    = 1'b0;
        #1;
        chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        step();
        step();
        @(negedge clock);
        #2 reset_n = 1'b1;

        // No requests: stays idle.
        step();
        chk_all("idle_noreq", 8'h00, 3'd0, 1'b0, 1'b0);

        // Basic grant, release, dead cycle, next client.
        req = 8'b0000_0110;
        step();
        chk_all("first_grant", 8'b0000_0010, 3'd1, 1'b1, 1'b0);
        release_grant = 1'b1;
        step();
        chk_all("dead_cycle", 8'h00, 3'd1, 1'b0, 1'b0);
        release_grant = 1'b0;
        step();
        chk_all("second_grant", 8'b0000_0100, 3'd2, 1'b1, 1'b0);
        release_grant = 1'b1;
        step();
        chk_all("release2", 8'h00, 3'd2, 1'b0, 1'b0);

        // Release while idle is ignored.
        req = 8'h00;
        step();
        chk_all("idle_release", 8'h00, 3'd2, 1'b0, 1'b0);
        release_grant = 1'b0;

        // Wrap from client 7 to client 0.
        req = 8'b1000_0000;
        step();
        chk_all("grant7", 8'b1000_0000, 3'd7, 1'b1, 1'b0);
        req           = 8'b1000_0001;
        release_grant = 1'b1;
        step();
        chk_all("release7", 8'h00, 3'd7, 1'b0, 1'b0);
        release_grant = 1'b0;
        step();
        chk_all("wrap_grant0", 8'b0000_0001, 3'd0, 1'b1, 1'b0);
        release_grant = 1'b1;
        step();
        release_grant = 1'b0;
        req           = 8'h00;
        step();
        chk_all("idle_after0", 8'h00, 3'd0, 1'b0, 1'b0);

        // MAX_HOLD expiry: four grant cycles, one timeout cycle, regrant.
        req = 8'b0000_1000;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_all($sformatf("hold_c%0d", c), 8'b0000_1000, 3'd3, 1'b1, 1'b0);
        end
        step();
        chk_all("timeout_pulse", 8'h00, 3'd3, 1'b0, 1'b1);
        step();
        chk_all("regrant3", 8'b0000_1000, 3'd3, 1'b1, 1'b0);

        // Release on the fourth grant cycle suppresses timeout.
        step();
        step();
        step();
        chk_all("fourth_cycle", 8'b0000_1000, 3'd3, 1'b1, 1'b0);
        release_grant = 1'b1;
        step();
        chk_all("release_no_timeout", 8'h00, 3'd3, 1'b0, 1'b0);
        release_grant = 1'b0;
        req           = 8'h00;
        step();
        chk_all("no_late_timeout", 8'h00, 3'd3, 1'b0, 1'b0);

        // Owner drops its request mid-grant; pointer is now 4.
        req = 8'b0011_1000;
        step();
        chk_all("grant4", 8'b0001_0000, 3'd4, 1'b1, 1'b0);
        req = 8'b0010_1000;
        step();
        chk_all("req_drop", 8'h00, 3'd4, 1'b0, 1'b0);
        step();
        chk_all("grant5", 8'b0010_0000, 3'd5, 1'b1, 1'b0);

        // Other request lines toggling do not disturb the grant.
        req = 8'b1110_1111 | 8'b0010_0000;
        step();
        chk_all("others_toggle", 8'b0010_0000, 3'd5, 1'b1, 1'b0);

        // Asynchronous reset mid-grant, then arbitration restarts from 0.
        #2 reset_n = 1'b0;
        #1;
        chk_all("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        req = 8'hFF;
        @(negedge clock);
        #2 reset_n = 1'b1;
        step();
        chk_all("after_reset", 8'b0000_0001, 3'd0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
